// File: rtl/adaptive_threshold_pkg.sv
// Shared definitions for the adaptive threshold engine.
// Frame geometry, pixel/accumulator widths, window size, FSM state
// encoding and the coordinate clamp used by the window address generator.
package adaptive_threshold_pkg;

    localparam int WIDTH   = 128;
    localparam int HEIGHT  = 128;
    localparam int COORD_W = 7;
    localparam int DATA_W  = 8;
    localparam int OFF_W   = 8;
    localparam int R       = 1;
    localparam int AREA    = (2 * R + 1) * (2 * R + 1);
    localparam int SUM_W   = 12;

    // Window counter width (counts 0..2R per axis).
    localparam int WIN_W = $clog2(2 * R + 1);

    // Signed width for c+dx / r+dy. A sign bit plus one headroom bit so
    // that (2^COORD_W - 1) + R cannot wrap into the negative range.
    localparam int ADDR_SW = COORD_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Clamp a signed coordinate into [0, maxv].
    function automatic logic [COORD_W-1:0] clamp(input logic signed [ADDR_SW-1:0] v,
                                                 input logic [COORD_W-1:0] maxv);
        logic [COORD_W-1:0] res;
        if (v[ADDR_SW-1]) begin
            res = '0;
        end else if (v[ADDR_SW-2:0] > {1'b0, maxv}) begin
            res = maxv;
        end else begin
            res = v[COORD_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/adaptive_threshold_if.sv
// Bus bundle between the threshold engine, the frame buffer read port and
// the downstream result consumer. Signal names are engine-relative.
//   oRdcol/oRdrow : read address to the frame buffer
//   iRddata       : read data, valid one cycle after the address
//   oValid/iReady : result handshake
//   oCol/oRow     : result pixel coordinates
//   oBin          : binarised result
// master = engine side, slave = frame buffer / consumer side.
interface adaptive_threshold_if;
    import adaptive_threshold_pkg::*;

    logic [COORD_W-1:0] oRdcol;
    logic [COORD_W-1:0] oRdrow;
    logic [DATA_W-1:0]  iRddata;
    logic               oValid;
    logic               iReady;
    logic [COORD_W-1:0] oCol;
    logic [COORD_W-1:0] oRow;
    logic               oBin;

    modport master (
        output oRdcol, oRdrow, oValid, oCol, oRow, oBin,
        input  iRddata, iReady
    );

    modport slave (
        input  oRdcol, oRdrow, oValid, oCol, oRow, oBin,
        output iRddata, iReady
    );

endinterface

// File: rtl/adaptive_threshold_engine_window_addr_gen.sv
// Window address generator: walks the (2R+1)x(2R+1) neighbourhood of
// pixel (col_i,row_i), dy outer and dx inner, clamping at the frame edges.
// Ports:
//   clock, reset     : system clock, async active-high reset
//   clear_i          : restart the walk at the window's first index
//   step_i           : advance one window index (wraps after the last)
//   col_i, row_i     : current centre pixel
//   rdcol_o, rdrow_o : clamped read address for the current index
//   centre_o         : current index is the window centre
//   last_o           : current index is the last of the window
module window_addr_gen
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_P  = WIDTH,
    parameter int HEIGHT_P = HEIGHT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] col_i,
    input  logic [COORD_W-1:0] row_i,
    output logic [COORD_W-1:0] rdcol_o,
    output logic [COORD_W-1:0] rdrow_o,
    output logic               centre_o,
    output logic               last_o
);

    localparam logic [WIN_W-1:0]          WIN_MAX = WIN_W'(2 * R);
    localparam logic [WIN_W-1:0]          WIN_MID = WIN_W'(R);
    localparam logic [COORD_W-1:0]        COL_MAX = COORD_W'(WIDTH_P - 1);
    localparam logic [COORD_W-1:0]        ROW_MAX = COORD_W'(HEIGHT_P - 1);
    localparam logic signed [ADDR_SW-1:0] R_S     = ADDR_SW'(R);

    logic [WIN_W-1:0] wx_q, wx_d;
    logic [WIN_W-1:0] wy_q, wy_d;

    logic signed [ADDR_SW-1:0] col_ext, row_ext, wx_ext, wy_ext;
    logic signed [ADDR_SW-1:0] col_s, row_s;

    always_comb begin
        wx_d = wx_q;
        wy_d = wy_q;
        if (clear_i) begin
            wx_d = '0;
            wy_d = '0;
        end else if (step_i) begin
            if (wx_q == WIN_MAX) begin
                wx_d = '0;
                wy_d = (wy_q == WIN_MAX) ? '0 : wy_q + 1'b1;
            end else begin
                wx_d = wx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wx_q <= '0;
            wy_q <= '0;
        end else begin
            wx_q <= wx_d;
            wy_q <= wy_d;
        end
    end

    // Counters run 0..2R; subtracting R gives the signed offset -R..R.
    assign col_ext = {2'b00, col_i};
    assign row_ext = {2'b00, row_i};
    assign wx_ext  = {{(ADDR_SW - WIN_W){1'b0}}, wx_q};
    assign wy_ext  = {{(ADDR_SW - WIN_W){1'b0}}, wy_q};
    assign col_s   = col_ext + wx_ext - R_S;
    assign row_s   = row_ext + wy_ext - R_S;

    assign rdcol_o  = clamp(col_s, COL_MAX);
    assign rdrow_o  = clamp(row_s, ROW_MAX);
    assign centre_o = (wx_q == WIN_MID) && (wy_q == WIN_MID);
    assign last_o   = (wx_q == WIN_MAX) && (wy_q == WIN_MAX);

endmodule

// File: rtl/adaptive_threshold_engine.sv
// Adaptive threshold engine: scans a buffered frame in raster order, sums
// each pixel's neighbourhood and emits 1 when centre*AREA exceeds
// sum + offset*AREA, i.e. when the centre is brighter than the local mean
// plus the offset.
// Ports:
//   clock, reset : system clock, async active-high reset
//   iStart       : one-cycle pulse, starts a frame scan when idle
//   iOffset      : threshold offset, captured at iStart
//   bus          : frame buffer read port and result handshake (master)
//   oBusy        : scan in progress (first FETCH through the oDone cycle)
//   oDone        : pulses in the cycle the last pixel is accepted
//
// state | meaning
// IDLE  | waiting for iStart
// FETCH | issuing AREA window reads, accumulating data from the previous read
// DRAIN | accumulating the final read
// OUT   | result presented, waiting for iReady
module adaptive_threshold_engine
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_P  = WIDTH,
    parameter int HEIGHT_P = HEIGHT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iStart,
    input  logic [OFF_W-1:0]     iOffset,
    adaptive_threshold_if.master bus,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(WIDTH_P - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(HEIGHT_P - 1);
    localparam logic [SUM_W:0]     AREA_X  = (SUM_W + 1)'(AREA);

    state_t state_q, state_d;

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] rdcol_q, rdcol_d;
    logic [COORD_W-1:0] rdrow_q, rdrow_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]  centre_q, centre_d;
    logic               dvalid_q, dvalid_d;
    logic               dcentre_q, dcentre_d;

    logic [COORD_W-1:0] gen_col, gen_row;
    logic               gen_centre, gen_last;
    logic               start, last_pix;
    logic [SUM_W:0]     lhs, rhs;

    assign start    = (state_q == IDLE) && iStart;
    assign last_pix = (col_q == COL_MAX) && (row_q == ROW_MAX);

    window_addr_gen #(
        .WIDTH_P  (WIDTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_addr (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (start),
        .step_i   (state_q == FETCH),
        .col_i    (col_q),
        .row_i    (row_q),
        .rdcol_o  (gen_col),
        .rdrow_o  (gen_row),
        .centre_o (gen_centre),
        .last_o   (gen_last)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        rdcol_d  = rdcol_q;
        rdrow_d  = rdrow_q;
        offset_d = offset_q;
        sum_d    = sum_q;
        centre_d = centre_q;
        oDone    = 1'b0;

        // Read data lags its address by one cycle, so the accumulate and
        // centre-capture strobes are the FETCH-cycle flags delayed by one.
        dvalid_d  = (state_q == FETCH);
        dcentre_d = (state_q == FETCH) && gen_centre;

        if (dvalid_q) begin
            sum_d = sum_q + {{(SUM_W - DATA_W){1'b0}}, bus.iRddata};
        end
        if (dcentre_q) begin
            centre_d = bus.iRddata;
        end

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    offset_d = iOffset;
                    col_d    = '0;
                    row_d    = '0;
                    sum_d    = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                rdcol_d = gen_col;
                rdrow_d = gen_row;
                if (gen_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (bus.iReady) begin
                    sum_d = '0;
                    if (last_pix) begin
                        oDone   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            rdcol_q   <= '0;
            rdrow_q   <= '0;
            offset_q  <= '0;
            sum_q     <= '0;
            centre_q  <= '0;
            dvalid_q  <= 1'b0;
            dcentre_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rdcol_q   <= rdcol_d;
            rdrow_q   <= rdrow_d;
            offset_q  <= offset_d;
            sum_q     <= sum_d;
            centre_q  <= centre_d;
            dvalid_q  <= dvalid_d;
            dcentre_q <= dcentre_d;
        end
    end

    // Both sides widened to SUM_W+1 bits; AREA*255*2 cannot overflow there.
    assign lhs = {{(SUM_W + 1 - DATA_W){1'b0}}, centre_q} * AREA_X;
    assign rhs = {1'b0, sum_q} + ({{(SUM_W + 1 - OFF_W){1'b0}}, offset_q} * AREA_X);

    // Outside FETCH the read address holds whatever was issued last.
    assign bus.oRdcol = (state_q == FETCH) ? gen_col : rdcol_q;
    assign bus.oRdrow = (state_q == FETCH) ? gen_row : rdrow_q;
    assign bus.oValid = (state_q == OUT);
    assign bus.oBin   = (state_q == OUT) && (lhs > rhs);
    assign bus.oCol   = col_q;
    assign bus.oRow   = row_q;
    assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_adaptive_threshold_engine.sv
module tb_adaptive_threshold_engine;
    import adaptive_threshold_pkg::*;

    localparam int TW        = 16;
    localparam int TH        = 16;
    localparam int NPIX      = TW * TH;
    localparam int FRAME_CYC = NPIX * 11;

    typedef struct packed { logic [6:0] c; logic [6:0] r; logic b; } res_t;
    typedef struct { int pat; int off; int mode; int restart; } frame_t;
    typedef struct { int frame; int c; int r; int b; } spot_t;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iStart  = 1'b0;
    logic [7:0] iOffset = 8'd0;
    logic       oBusy, oDone;

    adaptive_threshold_if bus ();

    adaptive_threshold_engine #(.WIDTH_P(TW), .HEIGHT_P(TH)) dut (
        .clock   (clock),
        .reset   (reset),
        .iStart  (iStart),
        .iOffset (iOffset),
        .bus     (bus),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 clock = ~clock;

    // Frame buffer model: one-cycle read latency; out-of-range reads give FF.
    logic [7:0] mem [TH][TW];
    always @(posedge clock) begin
        if (int'(bus.oRdcol) < TW && int'(bus.oRdrow) < TH)
            bus.iRddata <= mem[bus.oRdrow[3:0]][bus.oRdcol[3:0]];
        else
            bus.iRddata <= 8'hFF;
    end

    res_t sbq [$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    int   max_c = 0;
    int   max_r = 0;
    int   spot_v [TH][TW];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard consumer and frame statistics, sampled mid-cycle.
    always @(negedge clock) begin : mon
        res_t got, exp_r;
        if (!reset) begin
            if (oDone) done_cnt++;
            if (oBusy) begin
                busy_cyc++;
                if (int'(bus.oRdcol) > max_c) max_c = int'(bus.oRdcol);
                if (int'(bus.oRdrow) > max_r) max_r = int'(bus.oRdrow);
            end
            if (bus.oValid && bus.iReady) begin
                got = {bus.oCol, bus.oRow, bus.oBin};
                if (int'(bus.oCol) < TW && int'(bus.oRow) < TH)
                    spot_v[bus.oRow[3:0]][bus.oCol[3:0]] = int'(bus.oBin);
                n_vec++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got col %0d row %0d bin %0d, expected none",
                             bus.oCol, bus.oRow, bus.oBin);
                end else begin
                    exp_r = sbq.pop_front();
                    if (got != exp_r) begin
                        n_fail++;
                        $display("FAIL result: got col %0d row %0d bin %0d, expected col %0d row %0d bin %0d",
                                 got.c, got.r, got.b, exp_r.c, exp_r.r, exp_r.b);
                    end
                end
            end
        end
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int exp_bin(input int c, input int r, input int off);
        int s;
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += int'(mem[clampi(r + dy, TH - 1)][clampi(c + dx, TW - 1)]);
        return (int'(mem[r][c]) * 9 > s + off * 9) ? 1 : 0;
    endfunction

    task automatic fill(input int pat);
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++) begin
                case (pat)
                    0:       mem[r][c] = 8'd100;
                    1:       mem[r][c] = (r == 10 && c == 10) ? 8'd200 : 8'd50;
                    2:       mem[r][c] = 8'(c + r);
                    default: mem[r][c] = 8'($urandom_range(0, 255));
                endcase
            end
    endtask

    function automatic int out_word();
        return int'({bus.oValid, bus.oBin, oBusy, oDone,
                     bus.oCol, bus.oRow, bus.oRdcol, bus.oRdrow});
    endfunction

    task automatic start_frame(input int off);
        res_t e;
        int b;
        sbq.delete();
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++) begin
                b = exp_bin(c, r, off);
                e = {7'(c), 7'(r), b[0]};
                sbq.push_back(e);
                spot_v[r][c] = -1;
            end
        done_cnt = 0;
        busy_cyc = 0;
        max_c = 0;
        max_r = 0;
        @(posedge clock); #1;
        iOffset = 8'(off);
        iStart  = 1'b1;
        @(posedge clock); #1;
        iStart  = 1'b0;
        iOffset = ~8'(off);
    endtask

    task automatic run_frame(input int mode, input int restart, input int check_cyc);
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 8 * FRAME_CYC) begin
            @(posedge clock); #1;
            iStart = 1'b0;
            if (mode == 1) bus.iReady = ($urandom_range(0, 3) != 0);
            else           bus.iReady = 1'b1;
            if (restart >= 0 && bus.oValid &&
                (int'(bus.oRow) * TW + int'(bus.oCol)) == restart)
                iStart = 1'b1;
            guard++;
        end
        iStart = 1'b0;
        bus.iReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("done_count", done_cnt, 1);
        check("results_left", sbq.size(), 0);
        check("max_rdcol", max_c, TW - 1);
        check("max_rdrow", max_r, TH - 1);
        if (check_cyc != 0) check("frame_cycles", busy_cyc, FRAME_CYC);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        frame_t frames [4];
        spot_t  spots [9];
        int     exp_addr [9];
        int     to;
        int     lat;

        frames[0] = '{pat: 0, off: 0, mode: 0, restart: -1};
        frames[1] = '{pat: 1, off: 5, mode: 0, restart: 20};
        frames[2] = '{pat: 2, off: 0, mode: 1, restart: -1};
        frames[3] = '{pat: 3, off: int'($urandom_range(0, 30)), mode: 1, restart: -1};

        spots[0] = '{frame: 0, c: 0,  r: 0,  b: 0};
        spots[1] = '{frame: 0, c: 15, r: 15, b: 0};
        spots[2] = '{frame: 1, c: 10, r: 10, b: 1};
        spots[3] = '{frame: 1, c: 9,  r: 10, b: 0};
        spots[4] = '{frame: 1, c: 11, r: 11, b: 0};
        spots[5] = '{frame: 1, c: 0,  r: 0,  b: 0};
        spots[6] = '{frame: 2, c: 0,  r: 0,  b: 0};
        spots[7] = '{frame: 2, c: 15, r: 15, b: 1};
        spots[8] = '{frame: 2, c: 5,  r: 7,  b: 0};

        // (col<<8)|row for pixel (0,0) on a clamped 3x3 window
        exp_addr = '{0, 0, 256, 0, 0, 256, 1, 1, 257};

        bus.iReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", out_word(), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_outputs", out_word(), 0);

        for (int f = 0; f < 4; f++) begin
            fill(frames[f].pat);
            start_frame(frames[f].off);
            run_frame(frames[f].mode, frames[f].restart, (frames[f].mode == 0) ? 1 : 0);
            for (int s = 0; s < 9; s++)
                if (spots[s].frame == f)
                    check($sformatf("spot_f%0d_c%0d_r%0d", f, spots[s].c, spots[s].r),
                          spot_v[spots[s].r][spots[s].c], spots[s].b);
        end

        // Read address sequence for the corner pixel.
        fill(2);
        start_frame(0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            check($sformatf("addr_seq_k%0d", k),
                  int'(bus.oRdcol) * 256 + int'(bus.oRdrow), exp_addr[k]);
        end
        run_frame(0, -1, 1);

        // Backpressure: hold iReady low for 5 cycles at pixel (3,0).
        fill(3);
        start_frame(20);
        to = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            bus.iReady = 1'b1;
            if (bus.oValid && bus.oCol == 7'd3 && bus.oRow == 7'd0) begin
                bus.iReady = 1'b0;
                to = 0;
                break;
            end
        end
        check("bp_reach_pixel", to, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", int'(bus.oValid), 1);
            check("bp_col_row", int'(bus.oCol) * 256 + int'(bus.oRow), 3 * 256);
            check("bp_bin", int'(bus.oBin), exp_bin(3, 0, 20));
            check("bp_rdaddr", int'(bus.oRdcol) * 256 + int'(bus.oRdrow), 4 * 256 + 1);
        end
        @(posedge clock); #1;
        bus.iReady = 1'b1;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.oValid) begin
                lat = i;
                break;
            end
        end
        check("bp_next_latency", lat, 10);
        check("bp_next_pixel", int'(bus.oCol) * 256 + int'(bus.oRow), 4 * 256);
        run_frame(0, -1, 0);

        // Reset in the middle of a frame, then a clean restart.
        fill(3);
        start_frame(12);
        to = 1;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(posedge clock); #1;
            if (bus.oValid && (int'(bus.oRow) * TW + int'(bus.oCol)) == 100) begin
                to = 0;
                break;
            end
        end
        check("rst_reach_pixel", to, 0);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", out_word(), 0);
        sbq.delete();
        done_cnt = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", int'(oBusy), 0);
        start_frame(12);
        run_frame(0, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
